// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
package hazard_pkg;

  // Branch handling: hold fetch while a control instr sits in ID, or
  // keep fetching sequentially and flush on a taken redirect.
  typedef enum logic {
    BR_STALL      = 1'b0,
    BR_PREDICT_NT = 1'b1
  } br_mode_e;

  // Result latencies (cycles a dependent must wait after issue).
  localparam int NOFWD_ALU_LAT  = 2;
  localparam int NOFWD_LOAD_LAT = 2;
  localparam int FWD_ALU_LAT    = 0;
  localparam int FWD_LOAD_LAT   = 1;

  // Width of one scoreboard counter; never narrower than one bit so a
  // fully forwarded core still elaborates cleanly.
  function automatic int sb_cnt_width(input int alu_lat, input int load_lat);
    int m;
    m = (alu_lat > load_lat) ? alu_lat : load_lat;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: loadable, freezable down-counter that stops at zero.
module hazard_sb_entry #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         freeze_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         pending_o
);

  logic [W-1:0] cnt;

  // Load wins over countdown; a frozen pipeline keeps the slot unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (!freeze_i && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign pending_o = |cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside ID: scoreboard-based stalls, branch flush/stall,
// data-memory freeze and saturating stall/flush counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int ALU_LAT  = NOFWD_ALU_LAT,
  parameter int LOAD_LAT = NOFWD_LOAD_LAT,
  parameter int BR_MODE  = 0,
  parameter int PERF_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_is_rs1_i,
  input  logic              id_is_rs2_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_rd_wren_i,
  input  logic              id_is_load_i,
  input  logic              id_is_ctrl_i,
  input  logic              ex_is_ctrl_i,
  input  logic              br_sel_i,
  input  logic              mem_stall_i,
  output logic              pc_enable_o,
  output logic              id_enable_o,
  output logic              ex_enable_o,
  output logic              mem_enable_o,
  output logic              wb_enable_o,
  output logic              id_reset_no,
  output logic              ex_reset_no,
  output logic              mem_reset_no,
  output logic              wb_reset_no,
  output logic              data_hazard_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  localparam int CW = sb_cnt_width(ALU_LAT, LOAD_LAT);
  localparam logic [CW-1:0] ALU_V  = CW'(ALU_LAT);
  localparam logic [CW-1:0] LOAD_V = CW'(LOAD_LAT);

  logic [NUM_REGS-1:0] pend;
  logic                hz;
  logic                take;
  logic                issue;
  logic                rd_load;
  logic [CW-1:0]       load_val;

  assign take  = ex_is_ctrl_i & br_sel_i;
  assign hz    = id_valid_i & ((id_is_rs1_i & pend[id_rs1_addr_i]) |
                               (id_is_rs2_i & pend[id_rs2_addr_i]));
  assign issue = id_valid_i & ~mem_stall_i & ~take & ~hz;

  // x0 is never a real producer, so its slot is simply absent.
  assign rd_load  = issue & id_rd_wren_i & (id_rd_addr_i != '0);
  assign load_val = id_is_load_i ? LOAD_V : ALU_V;
  assign pend[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(.W(CW)) u_entry (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .freeze_i   (mem_stall_i),
      .load_i     (rd_load && (id_rd_addr_i == REG_AW'(r))),
      .load_val_i (load_val),
      .pending_o  (pend[r])
    );
  end

  assign pending_o = pend;

  // Pipeline control, highest priority first: memory freeze, taken
  // redirect, data hazard, then the stall-mode branch bubble.
  always_comb begin
    pc_enable_o   = 1'b1;
    id_enable_o   = 1'b1;
    ex_enable_o   = 1'b1;
    mem_enable_o  = 1'b1;
    wb_enable_o   = 1'b1;
    id_reset_no   = 1'b1;
    ex_reset_no   = 1'b1;
    mem_reset_no  = 1'b1;
    wb_reset_no   = 1'b1;
    data_hazard_o = 1'b0;
    if (mem_stall_i) begin
      pc_enable_o  = 1'b0;
      id_enable_o  = 1'b0;
      ex_enable_o  = 1'b0;
      mem_enable_o = 1'b0;
      wb_enable_o  = 1'b0;
    end else if (take) begin
      id_reset_no = 1'b0;
      ex_reset_no = 1'b0;
    end else if (hz) begin
      pc_enable_o   = 1'b0;
      id_enable_o   = 1'b0;
      ex_reset_no   = 1'b0;
      data_hazard_o = 1'b1;
    end else if ((BR_MODE == int'(BR_STALL)) && id_valid_i && id_is_ctrl_i) begin
      pc_enable_o = 1'b0;
      id_reset_no = 1'b0;
    end
  end

  // Saturating performance counters for hazard stalls and taken flushes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (data_hazard_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + PERF_W'(1);
      if (take && !mem_stall_i && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: three configurations (stall-mode, predict-not-taken,
// forwarding latencies) driven in lockstep and compared each cycle against
// a readiness-time model of the register scoreboard.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NC = 3;
  localparam int ALU_L [NC]  = '{NOFWD_ALU_LAT, NOFWD_ALU_LAT, FWD_ALU_LAT};
  localparam int LOAD_L [NC] = '{NOFWD_LOAD_LAT, NOFWD_LOAD_LAT, FWD_LOAD_LAT};
  localparam int BRM [NC]    = '{0, 1, 0};

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       id_valid_i, id_is_rs1_i, id_is_rs2_i, id_rd_wren_i;
  logic       id_is_load_i, id_is_ctrl_i, ex_is_ctrl_i, br_sel_i, mem_stall_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;

  logic [9:0]  ctl_obs   [NC];
  logic [31:0] pend_obs  [NC];
  logic [31:0] stall_obs [NC];
  logic [31:0] flush_obs [NC];

  always #5 clk_i = ~clk_i;

  for (genvar k = 0; k < NC; k++) begin : g_dut
    logic pc_en, id_en, ex_en, mem_en, wb_en, id_rn, ex_rn, mem_rn, wb_rn, dh;
    logic [31:0] pend, sc, fc;
    hazard_scoreboard #(.ALU_LAT(ALU_L[k]), .LOAD_LAT(LOAD_L[k]), .BR_MODE(BRM[k])) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
      .id_is_rs1_i(id_is_rs1_i), .id_is_rs2_i(id_is_rs2_i),
      .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i),
      .id_is_load_i(id_is_load_i), .id_is_ctrl_i(id_is_ctrl_i),
      .ex_is_ctrl_i(ex_is_ctrl_i), .br_sel_i(br_sel_i), .mem_stall_i(mem_stall_i),
      .pc_enable_o(pc_en), .id_enable_o(id_en), .ex_enable_o(ex_en),
      .mem_enable_o(mem_en), .wb_enable_o(wb_en),
      .id_reset_no(id_rn), .ex_reset_no(ex_rn), .mem_reset_no(mem_rn), .wb_reset_no(wb_rn),
      .data_hazard_o(dh), .pending_o(pend), .stall_cnt_o(sc), .flush_cnt_o(fc)
    );
    assign ctl_obs[k]   = {pc_en, id_en, ex_en, mem_en, wb_en, id_rn, ex_rn, mem_rn, wb_rn, dh};
    assign pend_obs[k]  = pend;
    assign stall_obs[k] = sc;
    assign flush_obs[k] = fc;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: a register is readable once the count of non-frozen edges
  // reaches the time its producer's result becomes visible.
  int          active   [NC];
  int          ready_at [NC][32];
  logic [31:0] m_stall  [NC];
  logic [31:0] m_flush  [NC];

  task automatic m_reset();
    for (int k = 0; k < NC; k++) begin
      active[k]  = 0;
      m_stall[k] = '0;
      m_flush[k] = '0;
      for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
    end
  endtask

  function automatic bit m_busy(input int k, input int r);
    return (r != 0) && (active[k] < ready_at[k][r]);
  endfunction

  function automatic logic [31:0] m_pend(input int k);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy(k, r);
    return v;
  endfunction

  function automatic bit m_hz(input int k);
    return id_valid_i && ((id_is_rs1_i && m_busy(k, int'(id_rs1_addr_i))) ||
                          (id_is_rs2_i && m_busy(k, int'(id_rs2_addr_i))));
  endfunction

  function automatic logic [9:0] m_ctl(input int k);
    logic pc, id, ex, mem, wb, idr, exr, dh;
    {pc, id, ex, mem, wb, idr, exr} = 7'h7f;
    dh = 1'b0;
    if (mem_stall_i) {pc, id, ex, mem, wb} = 5'b0;
    else if (ex_is_ctrl_i && br_sel_i) begin idr = 1'b0; exr = 1'b0; end
    else if (m_hz(k)) begin pc = 1'b0; id = 1'b0; exr = 1'b0; dh = 1'b1; end
    else if (BRM[k] == 0 && id_valid_i && id_is_ctrl_i) begin pc = 1'b0; idr = 1'b0; end
    return {pc, id, ex, mem, wb, idr, exr, 1'b1, 1'b1, dh};
  endfunction

  task automatic m_edge();
    for (int k = 0; k < NC; k++) begin
      bit hz, take, issue;
      hz    = m_hz(k);
      take  = ex_is_ctrl_i && br_sel_i;
      issue = id_valid_i && !mem_stall_i && !take && !hz;
      if (hz && !mem_stall_i && !take && m_stall[k] != '1) m_stall[k]++;
      if (take && !mem_stall_i && m_flush[k] != '1) m_flush[k]++;
      if (!mem_stall_i) active[k]++;
      if (issue && id_rd_wren_i && id_rd_addr_i != 0)
        ready_at[k][id_rd_addr_i] = active[k] + (id_is_load_i ? LOAD_L[k] : ALU_L[k]);
    end
  endtask

  // Inputs are held from just after one rising edge to just after the next.
  task automatic step();
    @(negedge clk_i);
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("ctl%0d", k), 64'(ctl_obs[k]), 64'(m_ctl(k)));
      chk($sformatf("pend%0d", k), 64'(pend_obs[k]), 64'(m_pend(k)));
      chk($sformatf("stall%0d", k), 64'(stall_obs[k]), 64'(m_stall[k]));
      chk($sformatf("flush%0d", k), 64'(flush_obs[k]), 64'(m_flush[k]));
    end
    @(posedge clk_i);
    if (!rst_i) m_edge();
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wr, input bit ld, input bit ct);
    id_valid_i = v;  id_rs1_addr_i = 5'(rs1); id_is_rs1_i = u1;
    id_rs2_addr_i = 5'(rs2); id_is_rs2_i = u2; id_rd_addr_i = 5'(rd);
    id_rd_wren_i = wr; id_is_load_i = ld; id_is_ctrl_i = ct;
  endtask

  task automatic set_misc(input bit exc, input bit br, input bit ms);
    ex_is_ctrl_i = exc; br_sel_i = br; mem_stall_i = ms;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any rising edge.
  task automatic async_reset();
    rst_i = 1'b1;
    #2;
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("arst_pend%0d", k), 64'(pend_obs[k]), 64'h0);
      chk($sformatf("arst_stall%0d", k), 64'(stall_obs[k]), 64'h0);
      chk($sformatf("arst_flush%0d", k), 64'(flush_obs[k]), 64'h0);
    end
    m_reset();
    rst_i = 1'b0;
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_misc(0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_pend", 64'(pend_obs[0]), 64'h0);
    chk("rst_stall", 64'(stall_obs[0]), 64'h0);
    rst_i = 1'b0;

    // add x5 ; add x6,x5,x1 -> two hazard cycles in the non-forwarding core
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); repeat (3) step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t1_stall_cnt", 64'(stall_obs[0]), 64'd2);
    chk("t1_fwd_stall_cnt", 64'(stall_obs[2]), 64'd0);

    // x5 busy but rs2 not read; write to x0 never tracked
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_id(1, 0, 0, 5, 0, 0, 1, 0, 0); step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // taken redirect coinciding with a hazard
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_id(1, 5, 1, 0, 0, 9, 1, 0, 0); set_misc(1, 1, 0); step();
    set_misc(0, 0, 0); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t3_flush_cnt", 64'(flush_obs[0]), 64'd1);

    // memory freeze while x5 is pending, then the remaining stalls
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_id(1, 5, 1, 0, 0, 9, 1, 0, 0); set_misc(0, 0, 1); repeat (3) step();
    set_misc(0, 0, 0); repeat (3) step();

    // control instruction in ID in both branch modes
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // load-use, then reset asserted in the middle of a stall
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0); step();
    set_id(1, 7, 1, 0, 0, 8, 1, 0, 0); repeat (2) step();
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0); step();
    set_id(1, 7, 1, 0, 0, 8, 1, 0, 0);
    async_reset();
    step();

    for (int i = 0; i < 2000; i++) begin
      set_id($urandom_range(0, 9) < 8,
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      set_misc($urandom_range(0, 4) == 0, $urandom_range(0, 1), $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 199) == 0) async_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
